// File: rtl/tdl_sample_pipe.sv
// tdl_sample_pipe
// Sampling pipeline for a tapped-delay-line TDC front end. A thermometer word
// is registered through NSTAGES stages with a valid bit travelling alongside.
// At the output stage each new valid word is compared with the previous valid
// word. A registered hit flag goes high when the two words differ, and a
// saturating counter records each hit.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (highest priority)
//   ce         advance enable; 0 holds every register
//   flush      clears all valid bits and hit (wins over ce)
//   in_valid   qualifies pipe_in
//   pipe_in    delay-line sample word (NFF bits)
//   pipe_out   output-stage data
//   out_valid  output-stage valid
//   hit        output word differs from the previous valid output word
//   hit_count  saturating count of hit assertions (CW bits)
module tdl_sample_pipe #(
    parameter int NFF     = 32,
    parameter int NSTAGES = 3,
    parameter int CW      = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce,
    input  logic           flush,
    input  logic           in_valid,
    input  logic [NFF-1:0] pipe_in,
    output logic [NFF-1:0] pipe_out,
    output logic           out_valid,
    output logic           hit,
    output logic [CW-1:0]  hit_count
);

    // Stage data and valid registers, one generate block per stage.
    genvar gi;
    generate
        for (gi = 1; gi <= NSTAGES; gi++) begin : g_stage
            logic [NFF-1:0] d_reg;
            logic           v_reg;
            logic [NFF-1:0] d_prev;
            logic           v_prev;

            if (gi == 1) begin : g_first
                assign d_prev = pipe_in;
                assign v_prev = in_valid;
            end else begin : g_chain
                assign d_prev = g_stage[gi-1].d_reg;
                assign v_prev = g_stage[gi-1].v_reg;
            end

            // Flush drops only the valid bits. The stale data stays in place
            // because it is never qualified again.
            always_ff @(posedge clk) begin
                if (rst) begin
                    d_reg <= '0;
                    v_reg <= 1'b0;
                end else if (flush) begin
                    v_reg <= 1'b0;
                end else if (ce) begin
                    d_reg <= d_prev;
                    v_reg <= v_prev;
                end
            end
        end
    endgenerate

    // The word about to enter the output stage. For a single stage this is
    // the raw input.
    logic [NFF-1:0] cmp_d;
    logic           cmp_v;

    generate
        if (NSTAGES == 1) begin : g_cmp_in
            assign cmp_d = pipe_in;
            assign cmp_v = in_valid;
        end else begin : g_cmp_stage
            assign cmp_d = g_stage[NSTAGES-1].d_reg;
            assign cmp_v = g_stage[NSTAGES-1].v_reg;
        end
    endgenerate

    logic [NFF-1:0] ref_reg;
    logic           hit_reg;
    logic [CW-1:0]  hit_count_reg;
    logic           hit_next;
    logic           count_full;

    assign hit_next   = cmp_v && (cmp_d != ref_reg);
    assign count_full = (hit_count_reg == {CW{1'b1}});

    // hit updates on the same edge as the output stage, so it stays aligned
    // with pipe_out and out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_reg       <= '0;
            hit_reg       <= 1'b0;
            hit_count_reg <= '0;
        end else if (flush) begin
            hit_reg <= 1'b0;
        end else if (ce) begin
            hit_reg <= hit_next;
            if (cmp_v) begin
                ref_reg <= cmp_d;
            end
            if (hit_next && !count_full) begin
                hit_count_reg <= hit_count_reg + 1'b1;
            end
        end
    end

    assign pipe_out  = g_stage[NSTAGES].d_reg;
    assign out_valid = g_stage[NSTAGES].v_reg;
    assign hit       = hit_reg;
    assign hit_count = hit_count_reg;

endmodule
